// File: rtl/pwm_duty_ramp_controller.sv
// pwm_duty_ramp_controller
// Walks the PWM generator's duty level toward a requested target, one
// 10% step at a time, using fixed-width increase/decrease pulses separated
// by a fixed idle gap. The generator's level is mirrored locally so the
// current duty is known without any feedback path from the PWM block.
module pwm_duty_ramp_controller #(
  parameter int PULSE_CYCLES = 10,
  parameter int GAP_CYCLES   = 10,
  parameter int MIN_LEVEL    = 1,
  parameter int MAX_LEVEL    = 9,
  parameter int RESET_LEVEL  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ui_target_duty,
  input  logic       ui_load,
  input  logic       ui_hold,
  output logic       uo_increase_duty,
  output logic       uo_decrease_duty,
  output logic [3:0] uo_duty_level,
  output logic       uo_busy,
  output logic       uo_done
);

  localparam logic [3:0] MIN_L   = 4'(MIN_LEVEL);
  localparam logic [3:0] MAX_L   = 4'(MAX_LEVEL);
  localparam logic [3:0] RST_L   = 4'(RESET_LEVEL);
  // The shared counter counts down to zero, so it is loaded with length-1.
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dir_up_q, dir_up_d;
  logic [3:0] level_q, level_d;
  logic [3:0] target_q, target_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Saturate a requested level into the commandable window.
  function automatic logic [3:0] clamp_level(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (v > MAX_L) begin
      r = MAX_L;
    end else if (v < MIN_L) begin
      r = MIN_L;
    end
    return r;
  endfunction

  // Target register input: a load lands immediately, so a decision made on
  // the same edge already sees the new value.
  always_comb begin
    target_d = target_q;
    if (ui_load) begin
      target_d = clamp_level(ui_target_duty);
    end
  end

  // Next-state, counter, level mirror and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    level_d  = level_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Idle compares against the registered target, so a fresh load
        // starts its first pulse one edge after it is captured.
        if (!ui_hold && (level_q != target_q)) begin
          state_d  = ST_PULSE;
          cnt_d    = PULSE_LD;
          dir_up_d = (target_q > level_q);
        end
      end

      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          // The mirrored level moves on the same edge the pulse drops,
          // which is when the generator registers the step.
          level_d = dir_up_q ? (level_q + 4'd1) : (level_q - 4'd1);
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          if (level_q == target_d) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (ui_hold) begin
            state_d = ST_IDLE;
          end else begin
            // Direction is re-evaluated so a mid-ramp load can reverse it.
            state_d  = ST_PULSE;
            cnt_d    = PULSE_LD;
            dir_up_d = (target_d > level_q);
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pulse outputs are decoded from the next state so that the
    // registered versions line up exactly with the PULSE state.
    inc_d  = (state_d == ST_PULSE) &&  dir_up_d;
    dec_d  = (state_d == ST_PULSE) && !dir_up_d;
    busy_d = (state_d != ST_IDLE);
  end

  // State, mirror and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      dir_up_q <= 1'b1;
      level_q  <= RST_L;
      target_q <= RST_L;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      level_q  <= level_d;
      target_q <= target_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign uo_increase_duty = inc_q;
  assign uo_decrease_duty = dec_q;
  assign uo_duty_level    = level_q;
  assign uo_busy          = busy_q;
  assign uo_done          = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp_controller.sv
// Testbench for pwm_duty_ramp_controller: directed scenarios followed by
// randomized load/hold/reset traffic, all checked against a timestamp-based
// reference model of the ramp behaviour.
module tb_pwm_duty_ramp_controller;

  localparam int P    = 10;
  localparam int G    = 10;
  localparam int MINL = 1;
  localparam int MAXL = 9;
  localparam int RSTL = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ui_target_duty;
  logic       ui_load;
  logic       ui_hold;
  logic       uo_increase_duty;
  logic       uo_decrease_duty;
  logic [3:0] uo_duty_level;
  logic       uo_busy;
  logic       uo_done;

  always #5 clk = ~clk;

  pwm_duty_ramp_controller #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .MIN_LEVEL   (MINL),
    .MAX_LEVEL   (MAXL),
    .RESET_LEVEL (RSTL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ui_target_duty  (ui_target_duty),
    .ui_load         (ui_load),
    .ui_hold         (ui_hold),
    .uo_increase_duty(uo_increase_duty),
    .uo_decrease_duty(uo_decrease_duty),
    .uo_duty_level   (uo_duty_level),
    .uo_busy         (uo_busy),
    .uo_done         (uo_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: level, target, whether a step is in flight,
  // the edge number at which the current pulse started, and its direction.
  int t       = 0;
  int m_level = RSTL;
  int m_target = RSTL;
  int m_busy  = 0;
  int m_start = 0;
  int m_up    = 1;
  int m_done  = 0;

  int   rise_inc = 0;
  int   rise_dec = 0;
  int   done_cnt = 0;
  int   last_done_t = 0;
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > MAXL) return MAXL;
    if (v < MINL) return MINL;
    return v;
  endfunction

  // One clock edge of the reference behaviour, evaluated from elapsed time
  // since the current pulse started rather than from a cycle counter.
  task automatic model_step();
    int nt;
    int age;
    if (rst) begin
      m_level  = RSTL;
      m_target = RSTL;
      m_busy   = 0;
      m_done   = 0;
      return;
    end
    m_done = 0;
    nt = ui_load ? clampv(int'(ui_target_duty)) : m_target;
    if (m_busy == 0) begin
      if (!ui_hold && m_level != m_target) begin
        m_busy  = 1;
        m_start = t;
        m_up    = (m_target > m_level) ? 1 : 0;
      end
    end else begin
      age = t - m_start;
      if (age == P) begin
        m_level = m_up ? m_level + 1 : m_level - 1;
      end else if (age == P + G) begin
        if (m_level == nt) begin
          m_busy = 0;
          m_done = 1;
        end else if (ui_hold) begin
          m_busy = 0;
        end else begin
          m_start = t;
          m_up    = (nt > m_level) ? 1 : 0;
        end
      end
    end
    m_target = nt;
  endtask

  // Advance one edge, update the model, then compare on the falling edge.
  task automatic tick();
    int ei;
    int ed;
    @(posedge clk);
    t++;
    model_step();
    @(negedge clk);
    ei = (m_busy != 0 && (t - m_start) < P && m_up != 0) ? 1 : 0;
    ed = (m_busy != 0 && (t - m_start) < P && m_up == 0) ? 1 : 0;
    chk("inc",   int'(uo_increase_duty), ei);
    chk("dec",   int'(uo_decrease_duty), ed);
    chk("level", int'(uo_duty_level), m_level);
    chk("busy",  int'(uo_busy), m_busy);
    chk("done",  int'(uo_done), m_done);
    chk("excl",  int'(uo_increase_duty & uo_decrease_duty), 0);
    if (uo_increase_duty && !prev_inc) rise_inc++;
    if (uo_decrease_duty && !prev_dec) rise_dec++;
    if (uo_done) begin
      done_cnt++;
      last_done_t = t;
    end
    prev_inc = uo_increase_duty;
    prev_dec = uo_decrease_duty;
  endtask

  task automatic clear_stats();
    rise_inc = 0;
    rise_dec = 0;
    done_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic load(input int v);
    ui_target_duty = 4'(v);
    ui_load = 1'b1;
    tick();
    ui_load = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!uo_done && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", int'(uo_done), 1);
  endtask

  int e;

  initial begin
    rst = 1'b1;
    ui_target_duty = 4'd0;
    ui_load = 1'b0;
    ui_hold = 1'b0;

    // Reset and quiet period.
    do_reset();
    chk("rst_level", int'(uo_duty_level), RSTL);
    chk("rst_busy",  int'(uo_busy), 0);
    clear_stats();
    repeat (50) tick();
    chk("rst_quiet_inc", rise_inc, 0);
    chk("rst_quiet_dec", rise_dec, 0);

    // Ramp up 5 -> 8.
    do_reset();
    clear_stats();
    load(8);
    e = t;
    wait_done(200);
    chk("up_done_lat", last_done_t - e, 1 + 3 * (P + G));
    repeat (3) tick();
    chk("up_inc_pulses", rise_inc, 3);
    chk("up_dec_pulses", rise_dec, 0);
    chk("up_level", int'(uo_duty_level), 8);
    chk("up_done_cnt", done_cnt, 1);

    // Clamp high then clamp low.
    do_reset();
    clear_stats();
    load(15);
    wait_done(400);
    tick();
    chk("clamp_hi_level", int'(uo_duty_level), 9);
    chk("clamp_hi_inc", rise_inc, 4);
    chk("clamp_hi_done", done_cnt, 1);
    clear_stats();
    load(0);
    wait_done(400);
    tick();
    chk("clamp_lo_level", int'(uo_duty_level), 1);
    chk("clamp_lo_dec", rise_dec, 8);
    chk("clamp_lo_done", done_cnt, 1);

    // Equal target: no activity.
    clear_stats();
    load(1);
    repeat (30) tick();
    chk("eq_pulses", rise_inc + rise_dec, 0);
    chk("eq_done", done_cnt, 0);

    // Reversal during the first pulse.
    do_reset();
    clear_stats();
    load(9);
    e = t;
    repeat (2) tick();
    load(3);
    while (t < e + P + 1) tick();
    chk("rev_first_level", int'(uo_duty_level), 6);
    wait_done(400);
    tick();
    chk("rev_level", int'(uo_duty_level), 3);
    chk("rev_inc", rise_inc, 1);
    chk("rev_dec", rise_dec, 3);

    // Hold asserted during the first gap.
    do_reset();
    clear_stats();
    load(8);
    e = t;
    while (t < e + P + 2) tick();
    ui_hold = 1'b1;
    repeat (30) tick();
    chk("hold_level", int'(uo_duty_level), 6);
    chk("hold_busy", int'(uo_busy), 0);
    chk("hold_done", done_cnt, 0);
    ui_hold = 1'b0;
    wait_done(200);
    tick();
    chk("hold_resume_inc", rise_inc, 3);
    chk("hold_resume_level", int'(uo_duty_level), 8);

    // Reset in the fourth cycle of a pulse.
    do_reset();
    clear_stats();
    load(8);
    e = t;
    while (t < e + 4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_inc", int'(uo_increase_duty), 0);
    chk("midrst_level", int'(uo_duty_level), RSTL);
    chk("midrst_busy", int'(uo_busy), 0);
    chk("midrst_done", done_cnt, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      ui_load        = ($urandom_range(0, 39) == 0);
      ui_target_duty = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) ui_hold = ~ui_hold;
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    ui_load = 1'b0;
    ui_hold = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
